// File: rtl/alu_arbiter_if.sv
// Requester-side port of the shared-ALU arbiter: operation request plus response channel.
interface alu_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ctl;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;

  // Requester view
  modport master (
    output req_valid, req_ctl, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  // Arbiter view
  modport slave (
    input  req_valid, req_ctl, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter time-sharing one 32-bit MIPS ALU between two requesters.
// One operation is outstanding at a time; results are registered and returned
// only to the issuing port. A held result can be consumed and replaced in the
// same cycle, so a port with rsp_ready tied high streams one op per cycle.
module alu_arbiter (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave port0,
  alu_arbiter_if.slave port1
);

  typedef enum logic [0:0] {StIdle, StHold} state_t;

  state_t           state_q;
  logic             own_q;
  logic             last_q;
  logic [1:0]       valid_q;
  logic [1:0][31:0] result_q;
  logic [1:0]       zero_q;
  logic [1:0]       illegal_q;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_ready;
  logic        winner;
  logic        can_accept;
  logic        accept;
  logic [3:0]  op_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        alu_illegal;

  assign req_valid = {port1.req_valid, port0.req_valid};
  assign rsp_ready = {port1.rsp_ready, port0.rsp_ready};

  // Winner: a lone valid requester wins; on a tie the one not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req_valid == 2'b11) begin
      winner = ~last_q;
    end else if (req_valid[1]) begin
      winner = 1'b1;
    end
  end

  // A slot is free when idle, or when the owner drains its result this cycle.
  assign can_accept = !reset && ((state_q == StIdle) || rsp_ready[own_q]);

  // Ready is only raised towards the winning, valid requester.
  always_comb begin
    req_ready    = 2'b00;
    req_ready[0] = can_accept && req_valid[0] && !winner;
    req_ready[1] = can_accept && req_valid[1] && winner;
  end

  assign accept = |(req_valid & req_ready);

  assign op_ctl = winner ? port1.req_ctl : port0.req_ctl;
  assign op_a   = winner ? port1.req_a   : port0.req_a;
  assign op_b   = winner ? port1.req_b   : port0.req_b;

  // Shared ALU: SLT is unsigned; unknown codes yield zero and flag illegal.
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (op_ctl)
      4'b0000: alu_result = op_a & op_b;
      4'b0001: alu_result = op_a | op_b;
      4'b0010: alu_result = op_a + op_b;
      4'b0110: alu_result = op_a - op_b;
      4'b0111: alu_result = {31'b0, (op_a < op_b)};
      default: alu_illegal = 1'b1;
    endcase
  end

  // FSM with per-port registered response outputs; non-owner outputs held at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      own_q     <= 1'b0;
      last_q    <= 1'b1;
      valid_q   <= 2'b00;
      result_q  <= '0;
      zero_q    <= 2'b00;
      illegal_q <= 2'b00;
    end else if (accept) begin
      state_q     <= StHold;
      own_q       <= winner;
      last_q      <= winner;
      valid_q     <= {winner, ~winner};
      result_q[0] <= winner ? 32'd0 : alu_result;
      result_q[1] <= winner ? alu_result : 32'd0;
      zero_q      <= {winner && (alu_result == '0), !winner && (alu_result == '0)};
      illegal_q   <= {winner && alu_illegal, !winner && alu_illegal};
    end else if ((state_q == StHold) && rsp_ready[own_q]) begin
      state_q   <= StIdle;
      valid_q   <= 2'b00;
      result_q  <= '0;
      zero_q    <= 2'b00;
      illegal_q <= 2'b00;
    end
  end

  assign port0.req_ready   = req_ready[0];
  assign port1.req_ready   = req_ready[1];
  assign port0.rsp_valid   = valid_q[0];
  assign port1.rsp_valid   = valid_q[1];
  assign port0.rsp_result  = result_q[0];
  assign port1.rsp_result  = result_q[1];
  assign port0.rsp_zero    = zero_q[0];
  assign port1.rsp_zero    = zero_q[1];
  assign port0.rsp_illegal = illegal_q[0];
  assign port1.rsp_illegal = illegal_q[1];

endmodule
